// File: rtl/riscv_dbus_ctrl.sv
// M-stage data-bus controller: turns load/store requests into word-aligned
// req/gnt/rvalid bus transactions, formats load data and flags faults.
module riscv_dbus_ctrl #(
    parameter int TIMEOUT_CYC = 255,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_rdM,
    input  logic              i_mem_wrM,
    input  logic [2:0]        i_funct3M,
    input  logic [ADDR_W-1:0] i_addrM,
    input  logic [31:0]       i_wdataM,
    output logic              o_bus_stallM,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [3:0]        o_bus_be,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_gnt,
    input  logic              i_bus_rvalid,
    input  logic [31:0]       i_bus_rdata,
    input  logic              i_bus_err,
    output logic [31:0]       o_rdataM,
    output logic              o_rdata_valid,
    output logic              o_misalignM,
    output logic              o_bus_errM
);

    localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [2:0]        r_f3;
    logic [1:0]        r_lane;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic              r_misal;

    logic w_rd;
    logic w_wr;
    logic w_valid;
    logic w_misal;
    logic w_unsup;
    logic w_bad;
    logic w_start;
    logic w_in_req;
    logic w_expire;

    function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   f_be = 4'b0001 << lane;
            2'b01:   f_be = 4'b0011 << lane;
            default: f_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   f_wdata = {4{d[7:0]}};
            2'b01:   f_wdata = {2{d[15:0]}};
            default: f_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lane, 3'b000} +: 8];
        h = d[{lane[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  f_load = {{24{b[7]}}, b};
            3'b001:  f_load = {{16{h[15]}}, h};
            3'b100:  f_load = {24'd0, b};
            3'b101:  f_load = {16'd0, h};
            default: f_load = d;
        endcase
    endfunction

    // Load wins when both strobes are high.
    assign w_rd    = i_mem_rdM;
    assign w_wr    = i_mem_wrM & ~i_mem_rdM;
    assign w_valid = w_rd | w_wr;

    assign w_misal = ((i_funct3M[1:0] == 2'b01) & i_addrM[0]) |
                     ((i_funct3M[1:0] == 2'b10) & (i_addrM[1:0] != 2'b00));
    assign w_unsup = w_rd ? ((i_funct3M == 3'b011) | (i_funct3M == 3'b110) | (i_funct3M == 3'b111))
                          : (i_funct3M > 3'b010);
    assign w_bad   = w_misal | w_unsup;
    assign w_start = (r_state == S_IDLE) & w_valid & ~w_bad;

    assign w_in_req = (r_state == S_REQ);
    assign w_expire = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_f3    <= 3'd0;
            r_lane  <= 2'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
            r_misal <= 1'b0;
        end else begin
            r_misal <= (r_state == S_IDLE) & w_valid & w_bad;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state <= S_REQ;
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
                        r_we    <= w_wr;
                        r_addr  <= {i_addrM[ADDR_W-1:2], 2'b00};
                        r_lane  <= i_addrM[1:0];
                        r_f3    <= i_funct3M;
                        r_be    <= f_be(i_funct3M[1:0], i_addrM[1:0]);
                        r_wdata <= f_wdata(i_funct3M[1:0], i_wdataM);
                    end
                end
                S_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A store is finished by gnt; a load granted on the last
                    // budget cycle has no time left for rvalid.
                    if (i_bus_gnt && r_we) begin
                        r_state <= S_DONE;
                        r_err   <= i_bus_err;
                    end else if (w_expire) begin
                        r_state <= S_DONE;
                        r_err   <= 1'b1;
                    end else if (i_bus_gnt) begin
                        r_state <= S_WAIT_R;
                    end
                end
                S_WAIT_R: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (i_bus_rvalid) begin
                        r_state <= S_DONE;
                        r_err   <= i_bus_err;
                        if (!i_bus_err) begin
                            r_rdata <= f_load(r_f3, r_lane, i_bus_rdata);
                        end
                    end else if (w_expire) begin
                        r_state <= S_DONE;
                        r_err   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_bus_stallM  = w_start | w_in_req | (r_state == S_WAIT_R);
    assign o_bus_req     = w_in_req;
    assign o_bus_we      = w_in_req & r_we;
    assign o_bus_addr    = w_in_req ? r_addr : '0;
    assign o_bus_be      = w_in_req ? r_be : 4'd0;
    assign o_bus_wdata   = w_in_req ? r_wdata : 32'd0;
    assign o_rdataM      = r_rdata;
    assign o_rdata_valid = (r_state == S_DONE) & ~r_we & ~r_err;
    assign o_bus_errM    = (r_state == S_DONE) & r_err;
    assign o_misalignM   = r_misal;

endmodule

// File: tb/tb_riscv_dbus_ctrl.sv
// Scoreboard bench for riscv_dbus_ctrl: driver pushes expectations from a
// byte-level reference model, a negedge monitor pops and compares.
module tb_riscv_dbus_ctrl;

    localparam int TO = 8;
    localparam int K_MIS = 0, K_ST = 1, K_LD = 2, K_ERR = 3;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          stalls;
    } done_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } bus_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_mem_rdM = 1'b0, i_mem_wrM = 1'b0;
    logic [2:0]  i_funct3M = 3'd0;
    logic [31:0] i_addrM = 32'd0, i_wdataM = 32'd0;
    logic        i_bus_gnt = 1'b0, i_bus_rvalid = 1'b0, i_bus_err = 1'b0;
    logic [31:0] i_bus_rdata = 32'd0;
    logic        o_bus_stallM, o_bus_req, o_bus_we, o_rdata_valid, o_misalignM, o_bus_errM;
    logic [31:0] o_bus_addr, o_bus_wdata, o_rdataM;
    logic [3:0]  o_bus_be;

    int n_chk = 0, n_err = 0;
    done_t done_q[$];
    bus_t  bus_q[$];
    int    stall_cnt = 0;
    logic  prev_stall = 1'b0;
    done_t e;
    bus_t  b;

    riscv_dbus_ctrl #(.TIMEOUT_CYC(TO), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_mem_rdM(i_mem_rdM), .i_mem_wrM(i_mem_wrM), .i_funct3M(i_funct3M),
        .i_addrM(i_addrM), .i_wdataM(i_wdataM),
        .o_bus_stallM(o_bus_stallM), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
        .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid), .i_bus_rdata(i_bus_rdata),
        .i_bus_err(i_bus_err),
        .o_rdataM(o_rdataM), .o_rdata_valid(o_rdata_valid),
        .o_misalignM(o_misalignM), .o_bus_errM(o_bus_errM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sizes in bytes, lanes, masks.
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic m_bad(input logic rd, input logic [2:0] f3, input logic [31:0] a);
        logic unsup;
        unsup = rd ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 > 2);
        return unsup || ((a % nbytes(f3)) != 0);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        int lane = int'(a % 4);
        return 4'(((1 << n) - 1) << lane);
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] w);
        logic [31:0] r;
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] d);
        int n = nbytes(f3);
        logic [31:0] sh, mask, v;
        sh   = d >> (8 * (a % 4));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v    = sh & mask;
        if (!f3[2] && n < 4 && sh[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // g: REQ cycles before gnt; r: WAIT_R cycles before rvalid.
    task automatic run_acc(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input int g,
                           input int r, input logic [31:0] rdat, input logic err);
        done_t d;
        bus_t  bb;
        logic  is_ld = rd;
        if (m_bad(is_ld, f3, a)) begin
            d.kind = K_MIS; d.data = 0; d.stalls = 0;
            done_q.push_back(d);
        end else begin
            bb.we = !is_ld; bb.addr = a & 32'hFFFF_FFFC; bb.be = m_be(f3, a); bb.wd = m_wd(f3, wd);
            bus_q.push_back(bb);
            d.kind   = err ? K_ERR : (is_ld ? K_LD : K_ST);
            d.data   = m_ld(f3, a, rdat);
            d.stalls = 1 + (g + 1) + (is_ld ? (r + 1) : 0);
            done_q.push_back(d);
        end
        i_mem_rdM = rd; i_mem_wrM = wr; i_funct3M = f3; i_addrM = a; i_wdataM = wd;
        tick();
        i_mem_rdM = 0; i_mem_wrM = 0; i_addrM = $urandom; i_wdataM = $urandom;
        if (m_bad(is_ld, f3, a)) begin
            tick();
        end else begin
            repeat (g) tick();
            i_bus_gnt = 1; i_bus_err = is_ld ? 1'b0 : err;
            tick();
            i_bus_gnt = 0; i_bus_err = 0;
            if (is_ld) begin
                repeat (r) tick();
                i_bus_rvalid = 1; i_bus_rdata = rdat; i_bus_err = err;
                tick();
                i_bus_rvalid = 0; i_bus_err = 0;
            end
            tick();
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {o_bus_stallM, o_bus_req, o_bus_we, o_bus_be, o_rdata_valid, o_misalignM, o_bus_errM}, 0);
        chk({name, "_data"}, {o_bus_addr, o_bus_wdata}, 0);
        chk({name, "_rdata"}, o_rdataM, 0);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            stall_cnt  = 0;
        end else begin
            if (o_bus_req) begin
                if (bus_q.size() == 0) chk("bus_req_unexpected", 1, 0);
                else begin
                    b = bus_q[0];
                    chk("bus_we", o_bus_we, b.we);
                    chk("bus_addr", o_bus_addr, b.addr);
                    chk("bus_be", o_bus_be, b.be);
                    if (b.we) chk("bus_wdata", o_bus_wdata, b.wd);
                    if (i_bus_gnt) void'(bus_q.pop_front());
                end
            end
            if ((prev_stall && !o_bus_stallM) || o_misalignM || o_rdata_valid || o_bus_errM) begin
                if (done_q.size() == 0) chk("done_unexpected", {o_misalignM, o_rdata_valid, o_bus_errM}, 3'b111);
                else begin
                    e = done_q.pop_front();
                    chk("done_flags", {o_misalignM, o_rdata_valid, o_bus_errM},
                        (e.kind == K_MIS) ? 3'b100 : (e.kind == K_LD) ? 3'b010 :
                        (e.kind == K_ERR) ? 3'b001 : 3'b000);
                    if (e.kind == K_LD) chk("load_data", o_rdataM, e.data);
                    chk("stall_cycles", stall_cnt, e.stalls);
                end
                stall_cnt = 0;
            end
            if (o_bus_stallM) stall_cnt++;
            prev_stall = o_bus_stallM;
        end
    end

    initial begin
        logic [2:0] ld_ok [5];
        logic       rd, wr;
        logic [2:0] f3;
        logic [31:0] a;
        ld_ok = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        repeat (3) tick();
        @(negedge clk);
        chk_all_zero("reset_outputs");
        @(posedge clk); #1;
        rst = 0;
        tick();

        run_acc(1, 0, 3'b010, 32'h100, 0, 0, 0, 32'hDEADBEEF, 0);
        run_acc(1, 0, 3'b000, 32'h203, 0, 1, 1, 32'h80FF_0000, 0);
        run_acc(1, 0, 3'b100, 32'h203, 0, 0, 2, 32'h80FF_0000, 0);
        run_acc(1, 0, 3'b101, 32'h202, 0, 0, 0, 32'h80FF_0000, 0);
        run_acc(0, 1, 3'b001, 32'h306, 32'h1234_ABCD, 4, 0, 0, 0);
        tick();
        run_acc(1, 0, 3'b010, 32'h102, 0, 0, 0, 0, 0);
        run_acc(0, 1, 3'b001, 32'h101, 32'h5555, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 40; i++) begin
            case ($urandom % 3)
                0: begin rd = 1; wr = 0; end
                1: begin rd = 0; wr = 1; end
                default: begin rd = 1; wr = 1; end
            endcase
            if ($urandom % 7 == 0) f3 = 3'($urandom);
            else if (rd) f3 = ld_ok[$urandom % 5];
            else f3 = 3'($urandom % 3);
            a = $urandom;
            if ($urandom % 5 != 0) a = a & ~32'(nbytes(f3) - 1);
            run_acc(rd, wr, f3, a, $urandom, int'($urandom % 4), int'($urandom % 3),
                    $urandom, ($urandom % 8) == 0);
            repeat ($urandom % 3) tick();
        end

        // Load that never sees rvalid: aborted after TO cycles in REQ/WAIT_R.
        begin
            done_t d;
            bus_t  bb;
            bb.we = 0; bb.addr = 32'h500; bb.be = 4'hF; bb.wd = 0;
            bus_q.push_back(bb);
            d.kind = K_ERR; d.data = 0; d.stalls = 1 + TO;
            done_q.push_back(d);
            i_mem_rdM = 1; i_funct3M = 3'b010; i_addrM = 32'h500;
            tick();
            i_mem_rdM = 0;
            i_bus_gnt = 1;
            tick();
            i_bus_gnt = 0;
            repeat (TO - 1) tick();
            tick();
            i_bus_rvalid = 1; i_bus_gnt = 1; i_bus_rdata = 32'h1111_2222;
            tick();
            i_bus_rvalid = 0; i_bus_gnt = 0;
            repeat (3) tick();
        end

        // Reset while waiting for read data.
        begin
            done_t d;
            bus_t  bb;
            bb.we = 0; bb.addr = 32'h400; bb.be = 4'hF; bb.wd = 0;
            bus_q.push_back(bb);
            d.kind = K_LD; d.data = 0; d.stalls = 3;
            done_q.push_back(d);
            i_mem_rdM = 1; i_funct3M = 3'b010; i_addrM = 32'h400;
            tick();
            i_mem_rdM = 0;
            i_bus_gnt = 1;
            tick();
            i_bus_gnt = 0;
            rst = 1;
            done_q.delete();
            bus_q.delete();
            tick();
            rst = 0;
            @(negedge clk);
            chk_all_zero("reset_mid_access");
            @(posedge clk); #1;
            i_bus_rvalid = 1; i_bus_rdata = 32'hCAFE_F00D;
            tick();
            i_bus_rvalid = 0;
            tick();
            run_acc(0, 1, 3'b010, 32'h600, 32'hA5A5_5A5A, 0, 0, 0, 0);
        end

        repeat (3) tick();
        chk("queues_drained", done_q.size() + bus_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
